// File: rtl/mrd_stage_wrback_pkg.sv
// ----------------------------------------------------------------------------
// mrd_stage_wrback_pkg
// Shared constants and types for the mixed-radix write-back stage.
//   wDATA / wADDR : lane data component width / bank address width
//   NLANE / NBANK : butterfly lanes (max radix 5) / RAM banks
//   BANK_INVALID  : bank_index code marking a lane as unused
//   wb_state_t    : write-back FSM states
// ----------------------------------------------------------------------------
package mrd_stage_wrback_pkg;

    localparam int wDATA = 30;
    localparam int wADDR = 10;
    localparam int wCNT  = 12;
    localparam int NLANE = 5;
    localparam int NBANK = 7;

    localparam logic [2:0] BANK_INVALID = 3'd7;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WR    = 2'd1,
        WB_DRAIN = 2'd2
    } wb_state_t;

    // Lane k takes part in a beat only when k < radix. Lane indices never
    // exceed NLANE-1, so comparing against the raw factor already caps the
    // radix at NLANE.
    function automatic logic lane_in_factor(input int lane, input logic [2:0] factor);
        return (32'(factor) > 32'(lane));
    endfunction

endpackage

// File: rtl/mrd_stage_wrback_if.sv
// ----------------------------------------------------------------------------
// mrd_stage_wrback_if
// Bus bundle between the butterfly, the write-back stage and the RAM banks.
//   in_valid / in_factor           : beat valid and radix of the beat
//   in_bank_index / in_bank_addr   : per-lane target bank and address
//   in_real / in_imag              : per-lane data
//   wren / wraddr / wrdata_*       : per-bank write port
// master : upstream side (drives beats, observes bank writes)
// slave  : write-back stage (consumes beats, drives bank writes)
// ----------------------------------------------------------------------------
interface mrd_stage_wrback_if;
    import mrd_stage_wrback_pkg::*;

    logic                              in_valid;
    logic [2:0]                        in_factor;
    logic [0:NLANE-1][2:0]             in_bank_index;
    logic [0:NLANE-1][wADDR-1:0]       in_bank_addr;
    logic [0:NLANE-1][wDATA-1:0]       in_real;
    logic [0:NLANE-1][wDATA-1:0]       in_imag;

    logic [0:NBANK-1]                  wren;
    logic [0:NBANK-1][wADDR-1:0]       wraddr;
    logic [0:NBANK-1][wDATA-1:0]       wrdata_real;
    logic [0:NBANK-1][wDATA-1:0]       wrdata_imag;

    modport master (
        output in_valid, in_factor, in_bank_index, in_bank_addr, in_real, in_imag,
        input  wren, wraddr, wrdata_real, wrdata_imag
    );

    modport slave (
        input  in_valid, in_factor, in_bank_index, in_bank_addr, in_real, in_imag,
        output wren, wraddr, wrdata_real, wrdata_imag
    );

endinterface

// File: rtl/mrd_lane2bank_xbar.sv
// ----------------------------------------------------------------------------
// mrd_lane2bank_xbar
// Combinational lane-to-bank crossbar. For every bank, picks the lowest
// active lane that targets it and forwards that lane's address and data.
//   i_active        : per-lane active mask
//   i_bank_index    : per-lane target bank
//   i_bank_addr     : per-lane address
//   i_real/i_imag   : per-lane data
//   o_bank_valid    : bank receives a lane this beat
//   o_bank_addr     : selected address (0 when bank not valid)
//   o_bank_real/imag: selected data (0 when bank not valid)
//   o_conflict      : some bank was targeted by two or more active lanes
// ----------------------------------------------------------------------------
module mrd_lane2bank_xbar
    import mrd_stage_wrback_pkg::*;
(
    input  logic [0:NLANE-1]             i_active,
    input  logic [0:NLANE-1][2:0]        i_bank_index,
    input  logic [0:NLANE-1][wADDR-1:0]  i_bank_addr,
    input  logic [0:NLANE-1][wDATA-1:0]  i_real,
    input  logic [0:NLANE-1][wDATA-1:0]  i_imag,
    output logic [0:NBANK-1]             o_bank_valid,
    output logic [0:NBANK-1][wADDR-1:0]  o_bank_addr,
    output logic [0:NBANK-1][wDATA-1:0]  o_bank_real,
    output logic [0:NBANK-1][wDATA-1:0]  o_bank_imag,
    output logic                         o_conflict
);

    logic [0:NBANK-1] w_bank_conflict;

    genvar gi;
    generate
        for (gi = 0; gi < NBANK; gi++) begin : g_bank
            logic [0:NLANE-1] w_hit;
            logic [2:0]       w_sel;
            logic             w_any;

            always_comb begin
                w_hit = '0;
                w_sel = '0;
                for (int k = 0; k < NLANE; k++) begin
                    w_hit[k] = i_active[k] && (i_bank_index[k] == 3'(gi));
                end
                // Scan downward so the lowest hitting lane is the last write.
                for (int k = NLANE - 1; k >= 0; k--) begin
                    if (w_hit[k]) begin
                        w_sel = 3'(k);
                    end
                end
            end

            assign w_any               = |w_hit;
            assign o_bank_valid[gi]    = w_any;
            assign o_bank_addr[gi]     = w_any ? i_bank_addr[w_sel] : '0;
            assign o_bank_real[gi]     = w_any ? i_real[w_sel]      : '0;
            assign o_bank_imag[gi]     = w_any ? i_imag[w_sel]      : '0;
            assign w_bank_conflict[gi] = ($countones(w_hit) > 1);
        end
    endgenerate

    assign o_conflict = |w_bank_conflict;

endmodule

// File: rtl/mrd_stage_wrback.sv
// ----------------------------------------------------------------------------
// mrd_stage_wrback
// Write-back stage: scatters up to 5 butterfly lanes into 7 RAM banks in
// place, counts beats per stage and pulses o_wr_end when the stage is done.
//   clk, rst_n       : clock, synchronous active-low reset
//   i_stage_start    : begin (or restart) a stage, latch i_expect_cnt
//   i_expect_cnt     : beats expected in this stage
//   bus (slave)      : beat input and per-bank write port
//   o_wr_busy        : stage in WR or DRAIN
//   o_wr_end         : one-cycle pulse, stage write complete
//   o_conflict_err   : sticky, two active lanes hit one bank
//   o_overrun_err    : sticky, beat arrived outside WR
// ----------------------------------------------------------------------------
module mrd_stage_wrback
    import mrd_stage_wrback_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_stage_start,
    input  logic [wCNT-1:0]      i_expect_cnt,
    mrd_stage_wrback_if.slave    bus,
    output logic                 o_wr_busy,
    output logic                 o_wr_end,
    output logic                 o_conflict_err,
    output logic                 o_overrun_err
);

    wb_state_t                   r_state;
    logic [wCNT-1:0]             r_beat_cnt;
    logic [wCNT-1:0]             r_expect_cnt;
    logic                        r_wr_busy;
    logic                        r_wr_end;
    logic                        r_conflict_err;
    logic                        r_overrun_err;

    logic [0:NBANK-1]            r_wren;
    logic [0:NBANK-1][wADDR-1:0] r_wraddr;
    logic [0:NBANK-1][wDATA-1:0] r_wrdata_real;
    logic [0:NBANK-1][wDATA-1:0] r_wrdata_imag;

    logic [0:NLANE-1]            w_active;
    logic [0:NBANK-1]            w_bank_valid;
    logic [0:NBANK-1][wADDR-1:0] w_bank_addr;
    logic [0:NBANK-1][wDATA-1:0] w_bank_real;
    logic [0:NBANK-1][wDATA-1:0] w_bank_imag;
    logic                        w_conflict;
    logic [wCNT-1:0]             w_cnt_inc;
    logic                        w_overrun;

    // Lanes only write while a stage is in WR; beats seen elsewhere are
    // flagged as overruns instead.
    genvar gi;
    generate
        for (gi = 0; gi < NLANE; gi++) begin : g_lane
            assign w_active[gi] = bus.in_valid
                               && (r_state == WB_WR)
                               && lane_in_factor(gi, bus.in_factor)
                               && (bus.in_bank_index[gi] != BANK_INVALID);
        end
    endgenerate

    mrd_lane2bank_xbar u_xbar (
        .i_active     (w_active),
        .i_bank_index (bus.in_bank_index),
        .i_bank_addr  (bus.in_bank_addr),
        .i_real       (bus.in_real),
        .i_imag       (bus.in_imag),
        .o_bank_valid (w_bank_valid),
        .o_bank_addr  (w_bank_addr),
        .o_bank_real  (w_bank_real),
        .o_bank_imag  (w_bank_imag),
        .o_conflict   (w_conflict)
    );

    assign w_cnt_inc = r_beat_cnt + 12'd1;
    assign w_overrun = bus.in_valid && (r_state != WB_WR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= WB_IDLE;
            r_beat_cnt     <= '0;
            r_expect_cnt   <= '0;
            r_wr_busy      <= 1'b0;
            r_wr_end       <= 1'b0;
            r_conflict_err <= 1'b0;
            r_overrun_err  <= 1'b0;
            r_wren         <= '0;
            r_wraddr       <= '0;
            r_wrdata_real  <= '0;
            r_wrdata_imag  <= '0;
        end else begin
            r_wr_end <= 1'b0;

            // Clear first so a same-cycle set overrides it.
            if (i_stage_start) begin
                r_conflict_err <= 1'b0;
                r_overrun_err  <= 1'b0;
            end
            if (w_conflict) begin
                r_conflict_err <= 1'b1;
            end
            if (w_overrun) begin
                r_overrun_err <= 1'b1;
            end

            // stage_start restarts from any state; an aborted stage never
            // reaches DRAIN->IDLE, so it produces no wr_end.
            if (i_stage_start) begin
                r_expect_cnt <= i_expect_cnt;
                r_beat_cnt   <= '0;
                r_wr_busy    <= 1'b1;
                if (i_expect_cnt == '0) begin
                    r_state <= WB_DRAIN;
                end else begin
                    r_state <= WB_WR;
                end
            end else begin
                case (r_state)
                    WB_IDLE: begin
                        r_wr_busy <= 1'b0;
                    end
                    WB_WR: begin
                        if (bus.in_valid) begin
                            r_beat_cnt <= w_cnt_inc;
                            if (w_cnt_inc == r_expect_cnt) begin
                                r_state <= WB_DRAIN;
                            end
                        end
                    end
                    WB_DRAIN: begin
                        // The last beat's bank write is on the port now;
                        // announce completion as we return to IDLE.
                        r_state   <= WB_IDLE;
                        r_wr_busy <= 1'b0;
                        r_wr_end  <= 1'b1;
                    end
                    default: begin
                        r_state   <= WB_IDLE;
                        r_wr_busy <= 1'b0;
                    end
                endcase
            end

            // The crossbar already zeroes address/data for idle banks.
            r_wren        <= w_bank_valid;
            r_wraddr      <= w_bank_addr;
            r_wrdata_real <= w_bank_real;
            r_wrdata_imag <= w_bank_imag;
        end
    end

    assign bus.wren        = r_wren;
    assign bus.wraddr      = r_wraddr;
    assign bus.wrdata_real = r_wrdata_real;
    assign bus.wrdata_imag = r_wrdata_imag;

    assign o_wr_busy       = r_wr_busy;
    assign o_wr_end        = r_wr_end;
    assign o_conflict_err  = r_conflict_err;
    assign o_overrun_err   = r_overrun_err;

endmodule

// File: tb/tb_mrd_stage_wrback.sv
// ----------------------------------------------------------------------------
// tb_mrd_stage_wrback
// Directed, table-driven bench for the write-back stage plus hand-written
// multi-cycle sequences (multi-beat stage, overrun, abort/restart,
// empty stage, sticky conflict, reset mid-stage).
// ----------------------------------------------------------------------------
module tb_mrd_stage_wrback;
    import mrd_stage_wrback_pkg::*;

    localparam logic [2:0] X = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stage_start = 1'b0;
    logic [11:0] expect_cnt = '0;
    logic        wr_busy, wr_end, conflict_err, overrun_err;

    mrd_stage_wrback_if bus();

    mrd_stage_wrback dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_stage_start  (stage_start),
        .i_expect_cnt   (expect_cnt),
        .bus            (bus),
        .o_wr_busy      (wr_busy),
        .o_wr_end       (wr_end),
        .o_conflict_err (conflict_err),
        .o_overrun_err  (overrun_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [0:4][2:0]  l_idx;
    logic [0:4][9:0]  l_addr;
    logic [0:4][29:0] l_re;
    logic [0:4][29:0] l_im;

    typedef struct {
        logic [2:0]      factor;
        logic [0:4][2:0] idx;
        logic [0:6][2:0] exp_lane;  // lane expected in each bank, X = none
        logic            exp_conf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [2:0] f, input logic [0:4][2:0] idx,
                              input logic [9:0] base, input int seed);
        for (int k = 0; k < 5; k++) begin
            l_idx[k]  = idx[k];
            l_addr[k] = base + 10'(k);
            l_re[k]   = 30'(32'h1000_0000 + seed * 256 + k);
            l_im[k]   = 30'(32'h2000_0000 + seed * 256 + k * 16);
        end
        bus.in_valid      = 1'b1;
        bus.in_factor     = f;
        bus.in_bank_index = l_idx;
        bus.in_bank_addr  = l_addr;
        bus.in_real       = l_re;
        bus.in_imag       = l_im;
    endtask

    task automatic idle_inputs();
        bus.in_valid      = 1'b0;
        bus.in_factor     = '0;
        bus.in_bank_index = '0;
        bus.in_bank_addr  = '0;
        bus.in_real       = '0;
        bus.in_imag       = '0;
    endtask

    task automatic check_banks(input string tag, input logic [0:6][2:0] lanes);
        logic [0:6]       ew;
        logic [0:6][9:0]  ea;
        logic [0:6][29:0] er;
        logic [0:6][29:0] ei;
        for (int b = 0; b < 7; b++) begin
            if (lanes[b] == X) begin
                ew[b] = 1'b0; ea[b] = '0; er[b] = '0; ei[b] = '0;
            end else begin
                ew[b] = 1'b1;
                ea[b] = l_addr[lanes[b]];
                er[b] = l_re[lanes[b]];
                ei[b] = l_im[lanes[b]];
            end
        end
        chk($sformatf("%s_wren", tag),   256'(bus.wren),        256'(ew));
        chk($sformatf("%s_wraddr", tag), 256'(bus.wraddr),      256'(ea));
        chk($sformatf("%s_wrre", tag),   256'(bus.wrdata_real), 256'(er));
        chk($sformatf("%s_wrim", tag),   256'(bus.wrdata_imag), 256'(ei));
    endtask

    task automatic check_all_zero(input string tag);
        chk($sformatf("%s_wren0", tag),  256'(bus.wren),        256'(0));
        chk($sformatf("%s_addr0", tag),  256'(bus.wraddr),      256'(0));
        chk($sformatf("%s_re0", tag),    256'(bus.wrdata_real), 256'(0));
        chk($sformatf("%s_im0", tag),    256'(bus.wrdata_imag), 256'(0));
        chk($sformatf("%s_busy0", tag),  256'(wr_busy),         256'(0));
        chk($sformatf("%s_end0", tag),   256'(wr_end),          256'(0));
        chk($sformatf("%s_conf0", tag),  256'(conflict_err),    256'(0));
        chk($sformatf("%s_ovr0", tag),   256'(overrun_err),     256'(0));
    endtask

    task automatic start_stage(input logic [11:0] n);
        stage_start = 1'b1;
        expect_cnt  = n;
        tick();
        stage_start = 1'b0;
    endtask

    initial begin
        int pulses;
        int pos;

        vecs[0] = '{3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, X, X},    1'b0};
        vecs[1] = '{3'd3, {3'd4, 3'd5, 3'd6, 3'd0, 3'd1}, {X, X, X, X, 3'd0, 3'd1, 3'd2},          1'b0};
        vecs[2] = '{3'd2, {3'd2, 3'd2, 3'd7, 3'd7, 3'd7}, {X, X, 3'd0, X, X, X, X},                1'b1};
        vecs[3] = '{3'd0, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, {X, X, X, X, X, X, X},                   1'b0};
        vecs[4] = '{3'd5, {3'd7, 3'd6, 3'd6, 3'd1, 3'd6}, {X, 3'd3, X, X, X, X, 3'd1},             1'b1};
        vecs[5] = '{3'd7, {3'd3, 3'd3, 3'd0, 3'd0, 3'd5}, {3'd2, X, X, 3'd0, X, 3'd4, X},          1'b1};
        vecs[6] = '{3'd4, {3'd1, 3'd7, 3'd3, 3'd5, 3'd2}, {X, 3'd0, X, 3'd2, X, 3'd3, X},          1'b0};
        vecs[7] = '{3'd1, {3'd6, 3'd0, 3'd0, 3'd0, 3'd0}, {X, X, X, X, X, X, 3'd0},                1'b0};

        idle_inputs();
        l_idx = '0; l_addr = '0; l_re = '0; l_im = '0;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        $display("txn reset: outputs checked");

        // Three-beat stage, lanes 0..4 to banks 0..4
        start_stage(12'd3);
        for (int i = 0; i < 3; i++) begin
            drive_beat(3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, 10'd10, 40 + i);
            tick();
            idle_inputs();
            chk($sformatf("s3_wren_b%0d", i), 256'(bus.wren), 256'(7'b1111100));
            chk($sformatf("s3_addr2_b%0d", i), 256'(bus.wraddr[2]), 256'(12));
            check_banks($sformatf("s3_b%0d", i), {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, X, X});
            chk($sformatf("s3_end_b%0d", i), 256'(wr_end), 256'(0));
        end
        chk("s3_busy_drain", 256'(wr_busy), 256'(1));
        tick();
        chk("s3_end", 256'(wr_end), 256'(1));
        chk("s3_wren_off", 256'(bus.wren), 256'(0));
        tick();
        chk("s3_end_low", 256'(wr_end), 256'(0));
        chk("s3_busy_low", 256'(wr_busy), 256'(0));
        $display("txn three-beat stage done");

        // Table: single-beat stages
        for (int v = 0; v < 8; v++) begin
            start_stage(12'd1);
            chk($sformatf("v%0d_conf_clr", v), 256'(conflict_err), 256'(0));
            chk($sformatf("v%0d_busy_wr", v), 256'(wr_busy), 256'(1));
            drive_beat(vecs[v].factor, vecs[v].idx, 10'(100 + v * 8), v);
            tick();
            idle_inputs();
            check_banks($sformatf("v%0d", v), vecs[v].exp_lane);
            chk($sformatf("v%0d_conf", v), 256'(conflict_err), 256'(vecs[v].exp_conf));
            chk($sformatf("v%0d_end_early", v), 256'(wr_end), 256'(0));
            tick();
            chk($sformatf("v%0d_end", v), 256'(wr_end), 256'(1));
            chk($sformatf("v%0d_wren_off", v), 256'(bus.wren), 256'(0));
            chk($sformatf("v%0d_conf_hold", v), 256'(conflict_err), 256'(vecs[v].exp_conf));
            tick();
            chk($sformatf("v%0d_end_low", v), 256'(wr_end), 256'(0));
            $display("txn vector %0d factor=%0d done", v, vecs[v].factor);
        end

        // Overrun in IDLE, cleared by stage_start
        drive_beat(3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, 10'd20, 60);
        tick();
        idle_inputs();
        chk("ovr_wren", 256'(bus.wren), 256'(0));
        chk("ovr_set", 256'(overrun_err), 256'(1));
        tick();
        chk("ovr_sticky", 256'(overrun_err), 256'(1));
        start_stage(12'd1);
        chk("ovr_clr", 256'(overrun_err), 256'(0));
        drive_beat(3'd1, {3'd3, 3'd0, 3'd0, 3'd0, 3'd0}, 10'd30, 61);
        tick();
        idle_inputs();
        check_banks("ovr_beat", {X, X, X, 3'd0, X, X, X});
        tick();
        chk("ovr_end", 256'(wr_end), 256'(1));
        // Beat in the same cycle as stage_start from IDLE
        stage_start = 1'b1;
        expect_cnt  = 12'd1;
        drive_beat(3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, 10'd40, 62);
        tick();
        stage_start = 1'b0;
        idle_inputs();
        chk("ovr_ss_set", 256'(overrun_err), 256'(1));
        chk("ovr_ss_wren", 256'(bus.wren), 256'(0));
        drive_beat(3'd2, {3'd5, 3'd6, 3'd0, 3'd0, 3'd0}, 10'd50, 63);
        tick();
        idle_inputs();
        check_banks("ovr_ss_beat", {X, X, X, X, X, 3'd0, 3'd1});
        tick();
        chk("ovr_ss_end", 256'(wr_end), 256'(1));
        tick();
        $display("txn overrun sequence done");

        // Abort mid-WR after 2 of 5 beats, restart with one beat
        start_stage(12'd5);
        for (int i = 0; i < 2; i++) begin
            drive_beat(3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, 10'd60, 70 + i);
            tick();
            idle_inputs();
        end
        start_stage(12'd1);
        chk("abort_busy", 256'(wr_busy), 256'(1));
        chk("abort_end0", 256'(wr_end), 256'(0));
        drive_beat(3'd2, {3'd1, 3'd4, 3'd0, 3'd0, 3'd0}, 10'd70, 72);
        tick();
        idle_inputs();
        check_banks("abort_beat", {X, 3'd0, X, X, 3'd1, X, X});
        pulses = 0;
        pos = -1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wr_end === 1'b1) begin
                pulses++;
                pos = i;
            end
        end
        chk("abort_pulses", 256'(pulses), 256'(1));
        chk("abort_pos", 256'(pos), 256'(0));
        $display("txn abort/restart done pulses=%0d", pulses);

        // Empty stage
        start_stage(12'd0);
        chk("empty_busy", 256'(wr_busy), 256'(1));
        chk("empty_end_early", 256'(wr_end), 256'(0));
        tick();
        chk("empty_end", 256'(wr_end), 256'(1));
        chk("empty_wren", 256'(bus.wren), 256'(0));
        tick();
        chk("empty_end_low", 256'(wr_end), 256'(0));
        chk("empty_idle", 256'(wr_busy), 256'(0));
        $display("txn empty stage done");

        // Conflict stays set until next stage_start
        start_stage(12'd2);
        drive_beat(3'd2, {3'd2, 3'd2, 3'd7, 3'd7, 3'd7}, 10'd80, 80);
        tick();
        drive_beat(3'd1, {3'd4, 3'd0, 3'd0, 3'd0, 3'd0}, 10'd90, 81);
        tick();
        idle_inputs();
        chk("conf_after_clean", 256'(conflict_err), 256'(1));
        tick(); tick(); tick();
        chk("conf_idle_hold", 256'(conflict_err), 256'(1));
        start_stage(12'd0);
        chk("conf_clr", 256'(conflict_err), 256'(0));
        tick(); tick();
        $display("txn sticky conflict done");

        // Reset mid-WR
        start_stage(12'd5);
        drive_beat(3'd2, {3'd3, 3'd3, 3'd0, 3'd0, 3'd0}, 10'd100, 90);
        tick();
        chk("rst_pre_conf", 256'(conflict_err), 256'(1));
        drive_beat(3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, 10'd110, 91);
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_mid");
        rst_n = 1'b1;
        idle_inputs();
        tick();
        drive_beat(3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, 10'd120, 92);
        tick();
        idle_inputs();
        chk("rst_idle_ovr", 256'(overrun_err), 256'(1));
        chk("rst_idle_wren", 256'(bus.wren), 256'(0));
        $display("txn reset mid-stage done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
